tick_period_meter: RTL and testbench

- Receive-side companion to the team's clock/tick dividers: measures spacing, in enabled clk cycles, between successive pulses on a tick input (e.g. a divide-by-N strobe).
- Reports the measured period, flags lock once the period is stable, and flags timeout when ticks stop.
- Used in bench checking and in-system monitoring of divider outputs.

---
 rtl/tpm_pkg.sv | 25 ++
 rtl/tpm_sat_cnt.sv | 34 +++
 rtl/tick_period_meter.sv | 145 ++++++++++++++
 tb/tb_tick_period_meter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/tpm_pkg.sv
// tpm_pkg
// Shared definitions for tick_period_meter and its sub-modules:
//   - FSM state enum and the matching legacy state constants
//   - legal range of the LOCK_CNT parameter
//   - width of the equal-period match counter
package tpm_pkg;

    typedef enum logic [1:0] {
        TPM_IDLE    = 2'd0,
        TPM_MEASURE = 2'd1,
        TPM_LOCKED  = 2'd2
    } tpm_state_e;

    // Plain constants so the state register can stay a simple logic vector.
    localparam logic [1:0] ST_IDLE    = TPM_IDLE;
    localparam logic [1:0] ST_MEASURE = TPM_MEASURE;
    localparam logic [1:0] ST_LOCKED  = TPM_LOCKED;

    localparam int LOCK_CNT_MIN = 2;
    localparam int LOCK_CNT_MAX = 15;

    // Holds values up to LOCK_CNT_MAX-1.
    localparam int MATCH_W = 4;

endpackage

// File: rtl/tpm_sat_cnt.sv
// tpm_sat_cnt
// W-bit up counter used to measure the spacing between ticks.
// Ports:
//   clk  - clock, rising edge
//   clr  - synchronous clear to 0 (priority over inc)
//   inc  - increment by one this cycle
//   cnt  - current count
//   tc   - terminal-count flag, high while cnt == 2^W-2
module tpm_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         tc
);

    localparam logic [W-1:0] ALL_ONES = '1;
    localparam logic [W-1:0] TC_VAL   = ALL_ONES - W'(1);

    // The owner clears the counter at the terminal count, so the hold at
    // all-ones only guards against wrapping if it is ever left running.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != ALL_ONES)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/tick_period_meter.sv
// tick_period_meter
// Measures the spacing, in enabled clk cycles, between successive tick
// pulses. Reports each measured period with a one-cycle valid pulse, raises
// locked once LOCK_CNT consecutive equal periods have been seen, and pulses
// timeout when no tick arrives within 2^W-1 enabled cycles.
// Optional build macro:
//   TICK_EDGE_EN - tick is treated as a level; its rising edge (sampled on
//                  enabled cycles) is the event being measured.
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous reset, active-high
//   clr     - synchronous soft clear, same effect as rst
//   en      - count enable; cycles with en=0 are invisible
//   tick    - pulse to be measured, sampled only when en=1
//   period  - last measured period (W bits)
//   valid   - one-cycle pulse, period updated this cycle
//   locked  - period stable for LOCK_CNT measurements
//   timeout - one-cycle pulse, no tick within 2^W-1 enabled cycles
module tick_period_meter
    import tpm_pkg::*;
#(
    parameter int W        = 8,
    parameter int LOCK_CNT = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         tick,
    output logic [W-1:0] period,
    output logic         valid,
    output logic         locked,
    output logic         timeout
);

    // Out-of-range LOCK_CNT values are pulled back into the legal range.
    localparam int LOCK_EFF = (LOCK_CNT < LOCK_CNT_MIN) ? LOCK_CNT_MIN :
                              (LOCK_CNT > LOCK_CNT_MAX) ? LOCK_CNT_MAX : LOCK_CNT;
    localparam logic [MATCH_W-1:0] MATCH_TOP = MATCH_W'(LOCK_EFF - 1);

    logic               sclr;
    logic               itick;
    logic [1:0]         state;
    logic               active;
    logic [MATCH_W-1:0] match;
    logic [MATCH_W-1:0] match_next;
    logic [W-1:0]       cnt;
    logic               cnt_tc;
    logic               cnt_clr;
    logic               cnt_inc;
    logic [W-1:0]       new_period;
    logic               same;

    assign sclr = rst | clr;

`ifdef TICK_EDGE_EN
    // Previous tick level, only advanced on enabled cycles so a level held
    // across disabled cycles still counts as one event.
    logic tick_q;

    always_ff @(posedge clk) begin
        if (sclr) begin
            tick_q <= 1'b0;
        end else if (en) begin
            tick_q <= tick;
        end
    end

    assign itick = tick & ~tick_q;
`else
    assign itick = tick;
`endif

    assign active = (state != ST_IDLE);

    // The counter restarts on every accepted tick (including the arming tick
    // in IDLE) and on timeout; it only runs while a measurement is open.
    assign cnt_clr = sclr | (en & itick) | (en & active & cnt_tc);
    assign cnt_inc = en & active & ~itick;

    tpm_sat_cnt #(
        .W (W)
    ) u_cnt (
        .clk (clk),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .cnt (cnt),
        .tc  (cnt_tc)
    );

    // The tick cycle itself is part of the interval, hence the +1.
    assign new_period = cnt + W'(1);
    assign same       = (new_period == period);

    always_comb begin
        match_next = '0;
        if (same) begin
            match_next = (match == MATCH_TOP) ? match : match + MATCH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            state   <= ST_IDLE;
            period  <= '0;
            valid   <= 1'b0;
            locked  <= 1'b0;
            timeout <= 1'b0;
            match   <= '0;
        end else begin
            valid   <= 1'b0;
            timeout <= 1'b0;
            if (en) begin
                case (state)
                    ST_IDLE: begin
                        if (itick) begin
                            state <= ST_MEASURE;
                        end
                    end
                    default: begin
                        // A tick on the threshold cycle wins over timeout.
                        if (itick) begin
                            period <= new_period;
                            valid  <= 1'b1;
                            match  <= match_next;
                            if (same && (match_next == MATCH_TOP)) begin
                                locked <= 1'b1;
                                state  <= ST_LOCKED;
                            end else if (!same) begin
                                locked <= 1'b0;
                                state  <= ST_MEASURE;
                            end
                        end else if (cnt_tc) begin
                            timeout <= 1'b1;
                            locked  <= 1'b0;
                            match   <= '0;
                            state   <= ST_IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tick_period_meter.sv
// tb_tick_period_meter
// Self-checking bench for tick_period_meter (W=4, LOCK_CNT=3). Directed and
// randomized stimulus is compared every cycle against an interval-based
// reference model of the measurement rules.
module tb_tick_period_meter;

    localparam int W    = 4;
    localparam int LC   = 3;
    localparam int MAXP = (1 << W) - 1;

    logic         clk;
    logic         rst;
    logic         clr;
    logic         en;
    logic         tick;
    logic [W-1:0] period;
    logic         valid;
    logic         locked;
    logic         timeout;

    int total;
    int bad;

    // Reference model state
    bit mArmed;
    int mGap;
    int mPeriod;
    int mRep;
    bit mLocked;
    bit mValid;
    bit mTimeout;
    bit mPrevLvl;

    tick_period_meter #(
        .W        (W),
        .LOCK_CNT (LC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .en      (en),
        .tick    (tick),
        .period  (period),
        .valid   (valid),
        .locked  (locked),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: mGap counts enabled cycles since the last accepted tick; a tick
    // closes the interval, reaching 2^W-1 without one is a timeout.
    task automatic modelStep(input bit r, input bit c, input bit e, input bit t);
        bit ev;
        int newP;
        mValid   = 1'b0;
        mTimeout = 1'b0;
        if (r || c) begin
            mArmed   = 1'b0;
            mGap     = 0;
            mPeriod  = 0;
            mRep     = 0;
            mLocked  = 1'b0;
            mPrevLvl = 1'b0;
        end else if (e) begin
            ev = t;
`ifdef TICK_EDGE_EN
            ev = t && !mPrevLvl;
            mPrevLvl = t;
`endif
            if (!mArmed) begin
                if (ev) begin
                    mArmed = 1'b1;
                    mGap   = 0;
                end
            end else begin
                mGap = mGap + 1;
                if (ev) begin
                    newP = mGap;
                    if (newP == mPeriod) begin
                        if (mRep < LC - 1) mRep = mRep + 1;
                    end else begin
                        mRep    = 0;
                        mLocked = 1'b0;
                    end
                    if (mRep == LC - 1) mLocked = 1'b1;
                    mPeriod = newP;
                    mValid  = 1'b1;
                    mGap    = 0;
                end else if (mGap == MAXP) begin
                    mTimeout = 1'b1;
                    mArmed   = 1'b0;
                    mLocked  = 1'b0;
                    mRep     = 0;
                    mGap     = 0;
                end
            end
        end
    endtask

    task automatic checkOutput();
        logic [W-1:0] expP;
        expP = mPeriod[W-1:0];
        total++;
        assert (period === expP) else begin
            bad++;
            $error("[TB] FAIL period t=%0t got=%0d exp=%0d", $time, period, expP);
        end
        total++;
        assert (valid === mValid) else begin
            bad++;
            $error("[TB] FAIL valid t=%0t got=%b exp=%b", $time, valid, mValid);
        end
        total++;
        assert (locked === mLocked) else begin
            bad++;
            $error("[TB] FAIL locked t=%0t got=%b exp=%b", $time, locked, mLocked);
        end
        total++;
        assert (timeout === mTimeout) else begin
            bad++;
            $error("[TB] FAIL timeout t=%0t got=%b exp=%b", $time, timeout, mTimeout);
        end
    endtask

    // Drive one clock of inputs, advance the model, check just after the edge.
    task automatic applyStimulus(input bit r, input bit c, input bit e, input bit t);
        rst  = r;
        clr  = c;
        en   = e;
        tick = t;
        @(posedge clk);
        modelStep(r, c, e, t);
        #1;
        checkOutput();
    endtask

    // n ticks spaced p enabled cycles apart, ending with the quiet gap.
    task automatic tickTrain(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
            for (int k = 1; k < p; k++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        mArmed   = 1'b0;
        mGap     = 0;
        mPeriod  = 0;
        mRep     = 0;
        mLocked  = 1'b0;
        mValid   = 1'b0;
        mTimeout = 1'b0;
        mPrevLvl = 1'b0;
        rst  = 1'b1;
        clr  = 1'b0;
        en   = 1'b0;
        tick = 1'b0;

        // Reset state
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

        // Reset held two cycles mid-measurement, then first tick gives no valid
        tickTrain(6, 3);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        tickTrain(4, 3);

        // Period 5 until locked, then one interval of 7 and re-lock at 7
        tickTrain(5, 7);
        tickTrain(7, 6);

        // en alternating, tick every 10 clk cycles, stray tick on en=0
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 10; k++) begin
                applyStimulus(1'b0, 1'b0, (k % 2) == 0, (k == 0) || (k == 3));
            end
        end

        // Longest measurable period: tick lands on the threshold cycle
        tickTrain(MAXP, 3);

        // Single tick then silence: timeout, then re-arm without valid
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 20; k++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tickTrain(3, 3);

        // Back-to-back ticks (tick held high for several cycles)
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        tickTrain(2, 2);

        // Locked, then clr on the same cycle as a tick
        tickTrain(4, 5);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        tickTrain(4, 2);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);

        // Random periodic trains with random lengths
        for (int b = 0; b < 12; b++) begin
            tickTrain(int'($urandom_range(1, MAXP)), int'($urandom_range(1, 6)));
        end

        // Fully random stimulus
        for (int i = 0; i < 800; i++) begin
            applyStimulus(($urandom % 200) == 0, ($urandom % 100) == 0,
                          ($urandom % 100) < 80, ($urandom % 100) < 15);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
